// File: rtl/sop_truth_sweeper.sv
// sop_truth_sweeper
//   N-input sum-of-products evaluator driven by a programmable minterm mask
//   (bit i = 1 -> f(i) = 1), with a direct registered lookup path and an
//   exhaustive sweep engine that streams every input combination over a
//   valid/ready handshake while counting the ones.
//   Optional feature macro: SOP_DONT_CARE_EN adds a don't-care mask
//   (cfg_dc_mask) and the per-index don't-care flag m_dc; don't-care
//   indices present m_o=0 and are not counted.
module sop_truth_sweeper #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [(1<<N_IN)-1:0]   cfg_mask,
`ifdef SOP_DONT_CARE_EN
    input  logic [(1<<N_IN)-1:0]   cfg_dc_mask,
    output logic                   m_dc,
`endif
    input  logic [N_IN-1:0]        in_vec,
    output logic                   o,
    input  logic                   start,
    output logic                   busy,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [N_IN-1:0]        m_idx,
    output logic                   m_o,
    output logic                   done,
    output logic [CNT_W-1:0]       ones_cnt
);

    localparam int M = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t            state_q;
    logic [M-1:0]      mask_q;
    logic              o_q;
    logic              busy_q;
    logic              m_valid_q;
    logic [N_IN-1:0]   m_idx_q;
    logic              m_o_q;
    logic              done_q;
    logic [CNT_W-1:0]  ones_cnt_q;

    logic              mask_we;
    logic [N_IN-1:0]   idx_d;
    logic [M-1:0]      out_mask;    // mask as seen by the stream (don't-cares forced to 0)
    logic [M-1:0]      start_mask;  // stream mask for the first index, honouring a same-cycle write

    // The mask is frozen for the whole sweep so the stream is self-consistent.
    assign mask_we = cfg_we && (state_q != S_SWEEP);
    assign idx_d   = m_idx_q + N_IN'(1);

`ifdef SOP_DONT_CARE_EN
    logic [M-1:0] dc_q;
    logic         m_dc_q;
    logic [M-1:0] start_dc;

    assign out_mask   = mask_q & ~dc_q;
    assign start_mask = mask_we ? (cfg_mask & ~cfg_dc_mask) : out_mask;
    assign start_dc   = mask_we ? cfg_dc_mask : dc_q;
    assign m_dc       = m_dc_q;

    // Don't-care mask register, loaded alongside the minterm mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_q <= '0;
        end else if (mask_we) begin
            dc_q <= cfg_dc_mask;
        end
    end

    // Don't-care flag tracks the presented index.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_dc_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  m_dc_q <= start ? start_dc[0] : 1'b0;
                S_SWEEP: if (m_ready) m_dc_q <= (m_idx_q == LAST_IDX) ? 1'b0 : dc_q[idx_d];
                default: m_dc_q <= 1'b0;
            endcase
        end
    end
`else
    assign out_mask   = mask_q;
    assign start_mask = mask_we ? cfg_mask : mask_q;
`endif

    // Minterm mask register; writes are dropped while a sweep is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= cfg_mask;
        end
    end

    // Direct lookup uses the mask as it stood before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= 1'b0;
        end else begin
            o_q <= mask_q[in_vec];
        end
    end

    // Sweep FSM with registered stream outputs and ones counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_idx_q    <= '0;
            m_o_q      <= 1'b0;
            done_q     <= 1'b0;
            ones_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_SWEEP;
                        busy_q     <= 1'b1;
                        m_valid_q  <= 1'b1;
                        m_idx_q    <= '0;
                        m_o_q      <= start_mask[0];
                        ones_cnt_q <= '0;
                    end
                end
                S_SWEEP: begin
                    if (m_ready) begin
                        if (m_o_q) begin
                            ones_cnt_q <= ones_cnt_q + CNT_W'(1);
                        end
                        if (m_idx_q == LAST_IDX) begin
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            m_valid_q <= 1'b0;
                            m_idx_q   <= '0;
                            m_o_q     <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            m_idx_q <= idx_d;
                            m_o_q   <= out_mask[idx_d];
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    m_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign o        = o_q;
    assign busy     = busy_q;
    assign m_valid  = m_valid_q;
    assign m_idx    = m_idx_q;
    assign m_o      = m_o_q;
    assign done     = done_q;
    assign ones_cnt = ones_cnt_q;

endmodule

// File: tb/tb_sop_truth_sweeper.sv
// Scoreboard bench for sop_truth_sweeper (N_IN=4): the stimulus process
// pushes expected stream beats and done records, a monitor pops them on
// every observed transfer / done pulse.
module tb_sop_truth_sweeper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_mask = '0;
    logic [3:0]  in_vec = '0;
    logic        o;
    logic        start = 1'b0;
    logic        busy;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  m_idx;
    logic        m_o;
    logic        done;
    logic [4:0]  ones_cnt;
`ifdef SOP_DONT_CARE_EN
    logic [15:0] cfg_dc_mask = '0;
    logic        m_dc;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       is_done;
        logic [3:0] idx;
        logic       mo;
        logic       dc;
        logic [4:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    sop_truth_sweeper #(.N_IN(4), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
`ifdef SOP_DONT_CARE_EN
        .cfg_dc_mask(cfg_dc_mask), .m_dc(m_dc),
`endif
        .in_vec(in_vec), .o(o), .start(start), .busy(busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_o(m_o),
        .done(done), .ones_cnt(ones_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compare every transfer and every done pulse against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {28'd0, m_idx}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_kind", 32'(e.is_done), 32'd0);
                    chk("beat_idx", {28'd0, m_idx}, {28'd0, e.idx});
                    chk("beat_mo", {31'd0, m_o}, {31'd0, e.mo});
`ifdef SOP_DONT_CARE_EN
                    chk("beat_dc", {31'd0, m_dc}, {31'd0, e.dc});
`endif
                end
            end
            if (!rst && done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 32'(e.is_done), 32'd1);
                    chk("done_ones_cnt", {27'd0, ones_cnt}, {27'd0, e.cnt});
                    chk("done_busy", {31'd0, busy}, 32'd0);
                    chk("done_valid", {31'd0, m_valid}, 32'd0);
                    chk("done_idx_wrap", {28'd0, m_idx}, 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sweep. load: write mk together with start. stall_at: index held
    // 3 cycles with m_ready=0. poke_at: cfg_we(FFFF)+start issued mid-sweep.
    // rst_at: reset asserted while that index is presented (sweep aborted).
    task automatic sweep(input logic [15:0] mk, input logic [15:0] dcm,
                         input bit load, input int stall_at, input int poke_at,
                         input int rst_at, input int ones);
        int   cyc = 0;
        int   stalls = 0;
        bit   poked = 0;
        bit   aborted = 0;
        for (int i = 0; i < 16; i++) begin
            if (rst_at < 0 || i < rst_at)
                exp_q.push_back('{1'b0, 4'(i), mk[i] & ~dcm[i], dcm[i], 5'd0});
        end
        if (rst_at < 0) exp_q.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 5'(ones)});
        cfg_we   = load;
        cfg_mask = mk;
`ifdef SOP_DONT_CARE_EN
        cfg_dc_mask = dcm;
`endif
        start = 1'b1;
        step();
        cfg_we = 1'b0;
        start  = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_cnt_clear", {27'd0, ones_cnt}, 32'd0);
        while (!done && cyc < 100) begin
            m_ready = 1'b1;
            cfg_we  = 1'b0;
            start   = 1'b0;
            if (m_valid && int'(m_idx) == rst_at) begin
                m_ready = 1'b0;
                rst = 1'b1;
                in_vec = 4'hF;
                step();
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (m_valid && int'(m_idx) == stall_at && stalls < 3) begin
                m_ready = 1'b0;
                stalls++;
                chk("stall_idx", {28'd0, m_idx}, 32'(stall_at));
                chk("stall_mo", {31'd0, m_o}, {31'd0, mk[stall_at]});
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
            end
            if (m_valid && int'(m_idx) == poke_at && !poked) begin
                cfg_we   = 1'b1;
                cfg_mask = 16'hFFFF;
                start    = 1'b1;
                poked    = 1;
            end
            step();
            cyc++;
        end
        m_ready = 1'b0;
        cfg_we  = 1'b0;
        start   = 1'b0;
        if (aborted) begin
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_ones_cnt", {27'd0, ones_cnt}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_idx", {28'd0, m_idx}, 32'd0);
            step();
            chk("rst_mask_cleared_o", {31'd0, o}, 32'd0);
        end else begin
            chk("sweep_cycles", 32'(cyc), 32'(16 + stalls));
            chk("done_seen", {31'd0, done}, 32'd1);
            step();
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end
        for (int k = 0; k < 20; k++) step();
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        rst = 1'b0;
        chk("reset_o", {31'd0, o}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_idx", {28'd0, m_idx}, 32'd0);
        chk("reset_mo", {31'd0, m_o}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ones_cnt", {27'd0, ones_cnt}, 32'd0);

        // Direct mode: same-cycle write not visible, then visible.
        cfg_we = 1'b1;
        cfg_mask = 16'h8000;
        in_vec = 4'hF;
        step();
        cfg_we = 1'b0;
        chk("direct_old_mask", {31'd0, o}, 32'd0);
        step();
        chk("direct_F", {31'd0, o}, 32'd1);
        in_vec = 4'hE;
        step();
        chk("direct_E", {31'd0, o}, 32'd0);

        // Full-rate sweep, mask written with start.
        sweep(16'hA5C3, 16'h0000, 1, -1, -1, -1, 8);
        // Backpressure at index 5.
        sweep(16'hA5C3, 16'h0000, 0, 5, -1, -1, 8);
        // Busy protection at index 7, then confirm mask unchanged.
        sweep(16'hA5C3, 16'h0000, 0, -1, 7, -1, 8);
        in_vec = 4'h2;
        step();
        step();
        chk("mask_protected", {31'd0, o}, 32'd0);
        in_vec = 4'h0;
        step();
        chk("mask_bit0", {31'd0, o}, 32'd1);
        // Reset mid-sweep at index 7.
        sweep(16'hA5C3, 16'h0000, 0, -1, -1, 7, 0);
`ifdef SOP_DONT_CARE_EN
        sweep(16'hA5C3, 16'h0003, 1, -1, -1, -1, 6);
`endif
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
